pad_strip: RTL and testbench
============================

# pad_strip

Receive-side counterpart of the zero-padding stage. It accepts a padded feature map (CH, H+2, W+2) as a serial element stream with a valid/ready handshake and discards the one-element border. It packs the interior (CH, H, W) into a wide register for the next layer, and flags any border element that is not zero. It sits between a serial source (memory reader or conv output serializer) and wide-bus consumers.

## Interface
- CH, 32, number of channels
- H, 3, interior rows (padded rows = H+2)
- W, 4, interior columns (padded columns = W+2)
- Element width is `data_len from num_data.v.

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin receiving a frame; sampled only in IDLE
- in_valid  in  1  in_data holds a valid element
- in_data  in  `data_len  padded-map element
- in_ready  out  1  block accepts an element this cycle
- q  out  CH*H*W*`data_len  packed interior map
- busy  out  1  high while in RECV
- done  out  1  one-cycle pulse when the frame is complete
- pad_err  out  1  sticky: a border element in the current frame was nonzero

## Operation
- Stream order is padded-flat order, index k = ch*(H+2)*(W+2) + r*(W+2) + c. Column is fastest, then row, then channel. This is the same element order as the padded output vector of zero_padding.
- The frame has CH*(H+2)*(W+2) beats, which is 960 at the default parameters.
- A beat is the condition in_valid && in_ready. Counters ch, r and c advance only on a beat: c wraps at W+1 into r++, r wraps at H+1 into ch++.
- Interior beat (1<=r<=H and 1<=c<=W):
  - Write q element index ch*H*W + (r-1)*W + (c-1), that is bits [idx*`data_len +: `data_len].
  - This places padded index i*30+7+j at interior index i*12+j for the first row, and so on, matching the zero_padding layout.
- Border beat: in_data is discarded. If in_data != 0, set pad_err.
- FSM:
  - IDLE:
    - in_ready=0, busy=0.
    - start=1 moves to RECV, clears the counters, and clears pad_err.
  - RECV:
    - in_ready=1, busy=1.
    - A beat at ch=CH-1, r=H+1, c=W+1 (the last beat) moves to DONE.
  - DONE:
    - in_ready=0, done=1 for exactly this cycle.
    - The state returns to IDLE on the next cycle.
- start outside IDLE is ignored.
- in_valid outside RECV is ignored, since no beat can occur.
- q is not cleared on start. Every interior element is overwritten during the frame, and q holds its value between frames.
- pad_err holds its value until the next accepted start or reset.

## Timing
- Reset values: state IDLE, counters 0, q=0, in_ready=0, busy=0, done=0, pad_err=0.
- in_ready and busy decode directly from the state register, with no combinational path from in_valid.
- start is sampled high in IDLE at cycle t. in_ready is high from cycle t+1.
- The last beat is accepted at cycle e. done=1 in cycle e+1 and in_ready=0 in cycle e+1. In cycle e+2 the state is IDLE.
- The earliest next start is sampled in cycle e+2.
- With in_valid held high, done rises 961 cycles after the start-sample cycle at default parameters.
- q and pad_err are final, including the last beat, in the cycle where done=1.
- A pad_err set by the last beat is visible alongside done.
- An in_valid gap stalls the counters and changes no other state.
- rst_n low at any point, including mid-frame, asynchronously forces all reset values. The partial frame is lost, and a new start is required.

## Test plan
- Reset: assert rst_n=0 mid-cycle with arbitrary inputs. Required: q=0, in_ready=0, busy=0, done=0, pad_err=0 immediately. in_ready stays 0 with in_valid=1 and no start.
- Back-to-back frame:
  - Stimulus: start, then 960 beats with in_valid always high. Border elements are 0; the interior element at padded index k carries value k.
  - Required: q[i*12+r*4+j] = i*30+(r+1)*6+(j+1), so element 0 = 7 and element 383 = 952. done is a single pulse 961 cycles after start. pad_err=0.
- Throttled: same frame with pseudo-random in_valid at about 50% duty. Required: q identical to the back-to-back case, done only after exactly 960 beats, in_ready constant 1 throughout RECV.
- Border error: padded index 0 = 1 and index 959 = 5, all other border elements 0. Required: pad_err=1 with done (index 959 is the last beat), interior q unaffected. A following start clears pad_err to 0 in the cycle after start is sampled.
- Reset mid-frame: reset after 500 beats. Required: q=0, state IDLE, in_ready=0. A subsequent full frame completes correctly with done after 960 beats.
- Round-trip and control:
  - Random d is passed through zero_padding, serialized, then fed to pad_strip. Required: q == d.
  - start pulses during RECV and DONE are ignored: no counter reset and no extra done.

Source files
------------

// File: rtl/pad_strip.sv
// pad_strip: strips the one-element border from a serial padded feature map,
// packs the interior into a wide register and flags nonzero border elements.
module pad_strip #(
   parameter int unsigned CH       = 32,
   parameter int unsigned H        = 3,
   parameter int unsigned W        = 4,
   parameter int unsigned DATA_LEN = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [DATA_LEN-1:0]          in_data,
   output logic                         in_ready,
   output logic [CH*H*W*DATA_LEN-1:0]   q,
   output logic                         busy,
   output logic                         done,
   output logic                         pad_err
);

   localparam int unsigned N_INT = CH * H * W;
   localparam int unsigned CHW   = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned RW    = $clog2(H + 2);
   localparam int unsigned CW    = $clog2(W + 2);
   localparam int unsigned IDXW  = (N_INT > 1) ? $clog2(N_INT) : 1;

   localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);
   localparam logic [RW-1:0]  R_LAST  = RW'(H + 1);
   localparam logic [CW-1:0]  C_LAST  = CW'(W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_DONE
   } state_t;

   state_t                      state_q, state_d;
   logic [CHW-1:0]              ch_q, ch_d;
   logic [RW-1:0]               r_q, r_d;
   logic [CW-1:0]               c_q, c_d;
   logic                        perr_q, perr_d;
   logic [CH*H*W*DATA_LEN-1:0]  q_q;
   logic                        interior;
   logic                        wr_en;
   logic [IDXW-1:0]             idx;

   assign interior = (r_q != '0) && (r_q <= RW'(H)) &&
                     (c_q != '0) && (c_q <= CW'(W));

   // Row/column are 1-based inside the padded frame; shift back by one for the interior.
   assign idx = IDXW'(ch_q) * IDXW'(H * W)
              + (IDXW'(r_q) - IDXW'(1)) * IDXW'(W)
              + IDXW'(c_q) - IDXW'(1);

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      r_d     = r_q;
      c_d     = c_q;
      perr_d  = perr_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RECV;
               ch_d    = '0;
               r_d     = '0;
               c_d     = '0;
               perr_d  = 1'b0;
            end
         end
         S_RECV: begin
            if (in_valid) begin
               if (interior) begin
                  wr_en = 1'b1;
               end else if (in_data != '0) begin
                  perr_d = 1'b1;
               end
               if (c_q == C_LAST) begin
                  c_d = '0;
                  if (r_q == R_LAST) begin
                     r_d = '0;
                     if (ch_q == CH_LAST) begin
                        state_d = S_DONE;
                     end else begin
                        ch_d = ch_q + CHW'(1);
                     end
                  end else begin
                     r_d = r_q + RW'(1);
                  end
               end else begin
                  c_d = c_q + CW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         r_q     <= '0;
         c_q     <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         r_q     <= r_d;
         c_q     <= c_d;
         perr_q  <= perr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (wr_en) begin
         for (int unsigned e = 0; e < N_INT; e++) begin
            if (idx == IDXW'(e)) begin
               q_q[e*DATA_LEN +: DATA_LEN] <= in_data;
            end
         end
      end
   end

   assign in_ready = (state_q == S_RECV);
   assign busy     = (state_q == S_RECV);
   assign done     = (state_q == S_DONE);
   assign pad_err  = perr_q;
   assign q        = q_q;

endmodule

// File: tb/tb_pad_strip.sv
// Directed bench for pad_strip: per-frame expectations are queued when a frame
// is driven and compared when the block signals done.
module tb_pad_strip;

   localparam int CH   = 32;
   localparam int H    = 3;
   localparam int W    = 4;
   localparam int DW   = 16;
   localparam int HP   = H + 2;
   localparam int WP   = W + 2;
   localparam int NPAD = CH * HP * WP;
   localparam int NINT = CH * H * W;
   localparam int QW   = NINT * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [QW-1:0] q;
   logic          busy;
   logic          done;
   logic          pad_err;

   pad_strip #(.CH(CH), .H(H), .W(W), .DATA_LEN(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .pad_err  (pad_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [QW-1:0] q;
      logic          perr;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] stream [NPAD];
   logic [QW-1:0] dvec;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_q(input string tag, input logic [QW-1:0] exp);
      int bad = -1;
      for (int i = NINT - 1; i >= 0; i--)
         if (q[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
      n_vec++;
      assert (q === exp) else begin
         n_err++;
         if (bad < 0) bad = 0;
         $error("FAIL %s: element %0d got %0h expected %0h", tag, bad,
                q[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_interior(input int k);
      int r, c;
      r = (k / WP) % HP;
      c = k % WP;
      return (r >= 1 && r <= H && c >= 1 && c <= W);
   endfunction

   function automatic int int_index(input int k);
      int ch, r, c;
      ch = k / (HP * WP);
      r  = (k / WP) % HP;
      c  = k % WP;
      return ch * H * W + (r - 1) * W + (c - 1);
   endfunction

   task automatic fill_count();
      for (int k = 0; k < NPAD; k++)
         stream[k] = is_interior(k) ? DW'(k) : '0;
   endtask

   task automatic push_model();
      exp_t e;
      e.q    = '0;
      e.perr = 1'b0;
      for (int k = 0; k < NPAD; k++) begin
         if (is_interior(k)) e.q[int_index(k)*DW +: DW] = stream[k];
         else if (stream[k] != '0) e.perr = 1'b1;
      end
      sb.push_back(e);
   endtask

   // abort_at >= 0: reset after that many beats; exp_total > 0: exact start-to-done cycles.
   task automatic send_frame(input bit throttle, input bit ctl_pulse,
                             input int abort_at, input int exp_total);
      int   beats = 0;
      int   cyc   = 0;
      bit   rdy_bad = 1'b0;
      bit   early_done = 1'b0;
      exp_t e;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ready_after_start", in_ready, 1);
      chk("perr_clear_on_start", pad_err, 0);
      while (beats < NPAD && cyc < 4 * NPAD) begin
         if (abort_at >= 0 && beats == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk_q("q_after_abort", '0);
            chk("ready_after_abort", in_ready, 0);
            chk("busy_after_abort", busy, 0);
            chk("perr_after_abort", pad_err, 0);
            tick();
            rst_n = 1'b1;
            tick();
            chk("idle_after_abort", in_ready, 0);
            in_valid = 1'b0;
            return;
         end
         in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? stream[beats] : DW'($urandom);
         start    = ctl_pulse && (cyc % 97 == 50);
         if (in_ready !== 1'b1) rdy_bad = 1'b1;
         if (done !== 1'b0) early_done = 1'b1;
         tick();
         if (in_valid) beats++;
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("ready_const_in_recv", rdy_bad, 0);
      chk("no_early_done", early_done, 0);
      chk("beats_before_done", beats, NPAD);
      chk("done_pulse", done, 1);
      chk("ready_low_in_done", in_ready, 0);
      if (exp_total > 0) chk("done_latency", cyc + 1, exp_total);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk_q("q_frame", e.q);
         chk("pad_err_at_done", pad_err, e.perr);
      end
      if (ctl_pulse) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_single_cycle", done, 0);
      chk("idle_after_done", busy, 0);
   endtask

   initial begin
      rst_n    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = '1;
      tick();
      tick();
      #3 rst_n = 1'b0;
      #1;
      chk_q("reset_q", '0);
      chk("reset_ready", in_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_perr", pad_err, 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("ready_without_start", in_ready, 0);
      chk("busy_without_start", busy, 0);
      in_valid = 1'b0;

      // back-to-back
      fill_count();
      push_model();
      send_frame(1'b0, 1'b0, -1, 961);
      chk("q_elem0", 32'(q[0 +: DW]), 7);
      chk("q_elem383", 32'(q[383*DW +: DW]), 952);

      // throttled
      push_model();
      send_frame(1'b1, 1'b0, -1, 0);

      // nonzero border at first and last beat
      stream[0]    = DW'(1);
      stream[NPAD-1] = DW'(5);
      push_model();
      send_frame(1'b0, 1'b0, -1, 961);

      // reset mid-frame, then a full frame
      fill_count();
      send_frame(1'b0, 1'b0, 500, 0);
      push_model();
      send_frame(1'b0, 1'b0, -1, 961);

      // random interior through a padding model, with stray start pulses
      for (int i = 0; i < NINT; i++) dvec[i*DW +: DW] = DW'($urandom);
      for (int k = 0; k < NPAD; k++)
         stream[k] = is_interior(k) ? dvec[int_index(k)*DW +: DW] : '0;
      sb.push_back('{q: dvec, perr: 1'b0});
      send_frame(1'b0, 1'b1, -1, 961);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
